// File: rtl/wb_uart_tx_pkg.sv
// Shared types and constants for the write-back UART streamer.
package wb_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         DATA_BITS = 8;

endpackage

// File: rtl/wb_tx_fifo.sv
// Synchronous FIFO with a combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module wb_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Buffers valid write-back words and sends each as 8N1 frames, LSB byte first.
// Define WB_UART_TX_SYNC_EN to prefix every word with a 0xA5 sync frame.
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [31:0]                   WB_Data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef WB_UART_TX_SYNC_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          pop, bit_tick;
    logic [31:0]   fifo_head;
    logic          fifo_full, fifo_empty;

    wb_tx_fifo #(.DEPTH(FIFO_DEPTH), .DW(32)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wb_valid),
        .pop   (pop),
        .wdata (WB_Data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_tick = (timer_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        pop       = 1'b0;
        if (state_q != IDLE) timer_d = bit_tick ? '0 : timer_q + TW'(1);
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                word_d  = fifo_head;
                idx_d   = '0;
                timer_d = '0;
                state_d = START;
            end
            START: if (bit_tick) state_d = DATA;
            DATA: if (bit_tick) begin
`ifdef WB_UART_TX_SYNC_EN
                // The sync frame leaves the data word untouched.
                if (idx_q != 3'd0) word_d = {1'b0, word_q[31:1]};
`else
                word_d = {1'b0, word_q[31:1]};
`endif
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = STOP;
            end
            STOP: if (bit_tick) begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = START;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_head;
                    idx_d   = '0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so tx never glitches.
        case (state_d)
            START: tx_d = 1'b0;
`ifdef WB_UART_TX_SYNC_EN
            DATA:  tx_d = (idx_d == 3'd0) ? SYNC_BYTE[bit_cnt_d] : word_d[0];
`else
            DATA:  tx_d = word_d[0];
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE) || !fifo_empty;
        ovf_d  = ovf_q || (wb_valid && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: decodes the serial line mid-bit and checks
// frame contents, latency, busy/overflow/fifo_level behaviour and reset.
module tb_wb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef WB_UART_TX_SYNC_EN
    localparam int FRAMES = 5;
`else
    localparam int FRAMES = 4;
`endif
    localparam int WC = FRAMES * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] WB_Data = '0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    wb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .WB_Data    (WB_Data),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, then samples each bit in the middle of its slot.
    task automatic recv_byte(input string tag, input logic [7:0] exp, input int exp_wait);
        int w = 0;
        logic [7:0] b = '0;
        do begin
            tick();
            w++;
        end while (tx !== 1'b0 && w < 4 * WC);
        chk({tag, " gap"}, w, exp_wait);
        repeat (2) tick();
        chk({tag, " start"}, tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            b[i] = tx;
        end
        repeat (4) tick();
        chk({tag, " stop"}, tx, 1'b1);
        chk({tag, " byte"}, b, exp);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input int first_wait);
        int wt = first_wait;
`ifdef WB_UART_TX_SYNC_EN
        recv_byte({tag, " sync"}, 8'hA5, wt);
        wt = 2;
`endif
        for (int i = 0; i < 4; i++) begin
            recv_byte($sformatf("%s b%0d", tag, i), w[8*i +: 8], wt);
            wt = 2;
        end
    endtask

    // Called two cycles before the last stop bit ends.
    task automatic busy_fall(input string tag);
        tick();
        chk({tag, " busy before end"}, busy, 1'b1);
        tick();
        chk({tag, " busy after end"}, busy, 1'b0);
        chk({tag, " tx idle"}, tx, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        int wt;

        // reset state
        repeat (2) tick();
        chk("rst tx", tx, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst overflow", overflow, 1'b0);
        chk("rst level", fifo_level, 3'd0);
        reset = 1'b1;
        tick();

        // single word
        WB_Data = 32'h12345678;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        chk("t1 level", fifo_level, 3'd1);
        expect_word("t1", 32'h12345678, 1);
        busy_fall("t1");
        chk("t1 overflow", overflow, 1'b0);

        // back-to-back words
        fork
            begin
                WB_Data = 32'hDEADBEEF;
                wb_valid = 1'b1;
                tick();
                chk("t2 level0", fifo_level, 3'd1);
                WB_Data = 32'h00000001;
                tick();
                chk("t2 level1", fifo_level, 3'd1);
                wb_valid = 1'b0;
            end
            begin
                tick();
                expect_word("t2a", 32'hDEADBEEF, 1);
                expect_word("t2b", 32'h00000001, 2);
            end
        join
        chk("t2 level end", fifo_level, 3'd0);
        busy_fall("t2");

        // overflow: 7 consecutive pushes, words 6 and 7 dropped
        do_reset();
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    WB_Data = 32'hC0DE0000 + 32'(i);
                    wb_valid = 1'b1;
                    tick();
                    chk($sformatf("t3 ovf after push %0d", i + 1), overflow, (i >= 5) ? 1'b1 : 1'b0);
                end
                wb_valid = 1'b0;
            end
            begin
                tick();
                for (int k = 0; k < 5; k++)
                    expect_word($sformatf("t3 w%0d", k + 1), 32'hC0DE0000 + 32'(k), (k == 0) ? 1 : 2);
            end
        join
        busy_fall("t3");
        chk("t3 level end", fifo_level, 3'd0);
        repeat (20) tick();
        chk("t3 tx stays idle", tx, 1'b1);
        chk("t3 overflow sticky", overflow, 1'b1);

        // full FIFO with push landing on the pop edge
        do_reset();
        for (int i = 0; i < 5; i++) begin
            WB_Data = 32'hF0000000 + 32'(i);
            wb_valid = 1'b1;
            tick();
        end
        wb_valid = 1'b0;
        chk("t4 level full", fifo_level, 3'd4);
        repeat (WC - 4) tick();
        chk("t4 level pre-pop", fifo_level, 3'd4);
        WB_Data = 32'hF0000005;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        chk("t4 level push+pop", fifo_level, 3'd4);
        chk("t4 overflow", overflow, 1'b0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 10 * WC) begin
            tick();
            cnt++;
        end
        chk("t4 drain cycles", cnt, 5 * WC);
        chk("t4 overflow end", overflow, 1'b0);

        // reset during the data bits of byte 2
        do_reset();
        fork
            begin
                WB_Data = 32'h11003344;
                wb_valid = 1'b1;
                tick();
                WB_Data = 32'h55667788;
                tick();
                wb_valid = 1'b0;
            end
            begin
                tick();
                wt = 1;
`ifdef WB_UART_TX_SYNC_EN
                recv_byte("t5 sync", 8'hA5, wt);
                wt = 2;
`endif
                recv_byte("t5 b0", 8'h44, wt);
                recv_byte("t5 b1", 8'h33, 2);
            end
        join
        repeat (10) tick();
        chk("t5 tx low mid-byte2", tx, 1'b0);
        chk("t5 level before rst", fifo_level, 3'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5 tx async", tx, 1'b1);
        chk("t5 level async", fifo_level, 3'd0);
        chk("t5 busy async", busy, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        WB_Data = 32'hA5A5A5A5;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        expect_word("t5 post", 32'hA5A5A5A5, 1);
        busy_fall("t5");

`ifdef WB_UART_TX_SYNC_EN
        // sync frame ahead of the data bytes, 200 cycles per word
        WB_Data = 32'h0000CAFE;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        recv_byte("t6 sync", 8'hA5, 1);
        recv_byte("t6 b0", 8'hFE, 2);
        recv_byte("t6 b1", 8'hCA, 2);
        recv_byte("t6 b2", 8'h00, 2);
        recv_byte("t6 b3", 8'h00, 2);
        busy_fall("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
